mem_wb_skid_register: RTL and testbench
=======================================

MEM_WB_SKID_REGISTER -- requirements
Module: mem_wb_skid_register

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of PCadd4, DataFromMemory and DataFromALU.
REQ-002 SHALL have parameter REG_W, default 5: width of WriteReg.
REQ-003 SHALL have parameter SRC_W, default 2: width of DBDataSrc.
REQ-004 SHALL have ports, clock and reset first:
- Clk  in  1  sole clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- MEM_Valid  in  1  upstream beat present.
- MEM_Ready  out  1  register can accept a beat.
- MEM_Flush  in  1  discard all held and incoming beats.
- MEM_DBDataSrc  in  SRC_W  writeback source select.
- MEM_RegWre  in  1  register-file write enable.
- MEM_PCadd4  in  DATA_W  PC+4.
- MEM_DataFromMemory  in  DATA_W  load data.
- MEM_DataFromALU  in  DATA_W  ALU result.
- MEM_WriteReg  in  REG_W  destination register.
- WB_Valid  out  1  head beat present.
- WB_Ready  in  1  WB stage consumes the head beat.
- WB_DBDataSrc, WB_RegWre, WB_PCadd4, WB_DataFromMemory, WB_DataFromALU, WB_WriteReg  out  same widths  head-beat fields.
- Occupancy  out  2  held beats (0..2).

Function
REQ-005 SHALL accept a beat on a rising edge where MEM_Valid=1, MEM_Ready=1 and MEM_Flush=0.
REQ-006 SHALL complete a transfer on a rising edge where WB_Valid=1 and WB_Ready=1.
REQ-007 SHALL be a two-entry elastic stage (main + skid) with states EMPTY, ONE and FULL.
REQ-008 SHALL drive MEM_Ready=1 in EMPTY and ONE, 0 in FULL, and 0 while Reset_n=0; MEM_Ready SHALL be decoded from state only, with no combinational path from WB_Ready.
REQ-009 SHALL take these transitions:
- EMPTY + accept -> ONE.
- ONE + accept + transfer -> ONE, main replaced.
- ONE + accept, no transfer -> FULL, beat into skid.
- ONE + transfer, no accept -> EMPTY.
- FULL + transfer -> ONE, skid moves to main.
- Otherwise hold.
REQ-010 SHALL give a latency of one cycle: a beat accepted at edge N SHALL appear on the WB outputs with WB_Valid=1 immediately after edge N when the register was EMPTY.
REQ-011 SHALL deliver beats in acceptance order, with no loss and no duplication.
REQ-012 SHALL keep WB_* fields stable while WB_Valid=1 and WB_Ready=0.
REQ-013 SHALL drive WB_RegWre as the stored RegWre ANDed with WB_Valid.
REQ-014 SHALL give MEM_Flush=1 at an edge priority over all other events: next state EMPTY, the incoming beat dropped, and any same-edge transfer still counted as consumed.
REQ-015 SHALL hold Occupancy equal to 0/1/2 for EMPTY/ONE/FULL, registered.
REQ-016 SHALL hold the WB_* data fields at their last values when EMPTY (no clearing); only WB_Valid and WB_RegWre are forced to 0.

Reset
REQ-017 SHALL, while Reset_n=0 and independent of Clk, force state EMPTY, WB_Valid=0, WB_RegWre=0, Occupancy=0, all WB_* data fields 0, and skid contents 0.
REQ-018 SHALL, on reset assertion mid-transfer, lose all held beats; the first accept SHALL be possible at the first rising edge after Reset_n deasserts.

Structure
REQ-019 SHALL take the state encoding (EMPTY=2'd0, ONE=2'd1, FULL=2'd2) from a shared pipeline package, which also holds the default DATA_W and REG_W constants.
REQ-020 SHALL pack payload fields into one SRC_W+1+3*DATA_W+REG_W vector internally.
REQ-021 SHALL contain one sub-module, pipe_payload_reg: a width-parametrised enable register with asynchronous active-low clear, instantiated for main and skid.

Verification
REQ-022 Bench SHALL cover these directed scenarios:
- Single beat: PCadd4=32'h12341234, DBDataSrc=1, RegWre=1, WriteReg=5'b10101, WB_Ready=1 -> outputs match one cycle later, WB_Valid high for 1 cycle, Occupancy 1 then 0.
- Back-pressure: WB_Ready=0, two beats (DataFromALU 32'h5A5A5A5A then 32'h5A) -> Occupancy=2, MEM_Ready=0, head stays 32'h5A5A5A5A; release WB_Ready -> 32'h5A5A5A5A then 32'h5A delivered in order.
- Full throughput: MEM_Valid=WB_Ready=1 for 8 cycles with DataFromMemory 1..8 -> 8 beats out in order, Occupancy never exceeds 1.
- Flush in FULL with simultaneous MEM_Valid -> next cycle WB_Valid=0, Occupancy=0, flushed beats never appear.
- Reset_n pulled low mid-cycle in ONE -> all outputs 0 immediately; after release a new beat (WriteReg=5'b10) passes normally.

Source files
------------

// File: rtl/mem_wb_skid_register_pkg.sv
// rtl/mem_wb_skid_register_pkg.sv - shared pipeline state encoding and default widths
package mem_wb_skid_register_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipeState_e;

  localparam int PIPE_DATA_W = 32;
  localparam int PIPE_REG_W  = 5;

endpackage

// File: rtl/pipe_payload_reg.sv
// rtl/pipe_payload_reg.sv - width-parametrised enable register with async active-low clear
module pipe_payload_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         resetN,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_wb_skid_register.sv
// rtl/mem_wb_skid_register.sv - two-entry elastic MEM/WB pipeline register (main + skid)
module mem_wb_skid_register
  import mem_wb_skid_register_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int REG_W  = PIPE_REG_W,
  parameter int SRC_W  = 2
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              MEM_Valid,
  output logic              MEM_Ready,
  input  logic              MEM_Flush,
  input  logic [SRC_W-1:0]  MEM_DBDataSrc,
  input  logic              MEM_RegWre,
  input  logic [DATA_W-1:0] MEM_PCadd4,
  input  logic [DATA_W-1:0] MEM_DataFromMemory,
  input  logic [DATA_W-1:0] MEM_DataFromALU,
  input  logic [REG_W-1:0]  MEM_WriteReg,
  output logic              WB_Valid,
  input  logic              WB_Ready,
  output logic [SRC_W-1:0]  WB_DBDataSrc,
  output logic              WB_RegWre,
  output logic [DATA_W-1:0] WB_PCadd4,
  output logic [DATA_W-1:0] WB_DataFromMemory,
  output logic [DATA_W-1:0] WB_DataFromALU,
  output logic [REG_W-1:0]  WB_WriteReg,
  output logic [1:0]        Occupancy
);

  localparam int PW = SRC_W + 1 + 3 * DATA_W + REG_W;

  pipeState_e state, nextState;
  logic accept, transfer;
  logic mainEn, skidEn, mainFromSkid;
  logic storedRegWre;
  logic [PW-1:0] inPayload, mainD, mainQ, skidQ;

  assign inPayload = {MEM_DBDataSrc, MEM_RegWre, MEM_PCadd4,
                      MEM_DataFromMemory, MEM_DataFromALU, MEM_WriteReg};

  // Ready depends only on state (and reset), never on WB_Ready.
  assign MEM_Ready = Reset_n & (state != FULL);
  assign WB_Valid  = (state != EMPTY);
  assign accept    = MEM_Valid & MEM_Ready & ~MEM_Flush;
  assign transfer  = WB_Valid & WB_Ready;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= EMPTY;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState    = state;
    mainEn       = 1'b0;
    skidEn       = 1'b0;
    mainFromSkid = 1'b0;
    if (MEM_Flush) begin
      nextState = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            nextState = ONE;
            mainEn    = 1'b1;
          end
        end
        ONE: begin
          if (accept && transfer) begin
            mainEn = 1'b1;
          end else if (accept) begin
            nextState = FULL;
            skidEn    = 1'b1;
          end else if (transfer) begin
            nextState = EMPTY;
          end
        end
        FULL: begin
          if (transfer) begin
            nextState    = ONE;
            mainEn       = 1'b1;
            mainFromSkid = 1'b1;
          end
        end
        default: nextState = EMPTY;
      endcase
    end
  end

  assign mainD = mainFromSkid ? skidQ : inPayload;

  pipe_payload_reg #(.W(PW)) mainReg (
    .clk    (Clk),
    .resetN (Reset_n),
    .en     (mainEn),
    .d      (mainD),
    .q      (mainQ)
  );

  pipe_payload_reg #(.W(PW)) skidReg (
    .clk    (Clk),
    .resetN (Reset_n),
    .en     (skidEn),
    .d      (inPayload),
    .q      (skidQ)
  );

  // Data fields hold their last value when empty; only the write enable is qualified.
  assign {WB_DBDataSrc, storedRegWre, WB_PCadd4,
          WB_DataFromMemory, WB_DataFromALU, WB_WriteReg} = mainQ;
  assign WB_RegWre = storedRegWre & WB_Valid;
  assign Occupancy = state;

endmodule

// File: tb/tb_mem_wb_skid_register.sv
// tb/tb_mem_wb_skid_register.sv - self-checking bench for mem_wb_skid_register
module tb_mem_wb_skid_register;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int SW = 2;

  typedef struct packed {
    logic [SW-1:0] src;
    logic          rw;
    logic [DW-1:0] pc;
    logic [DW-1:0] mem;
    logic [DW-1:0] alu;
    logic [RW-1:0] wr;
  } beat_t;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic          Reset_n, MEM_Valid, MEM_Ready, MEM_Flush, WB_Valid, WB_Ready, WB_RegWre;
  logic [SW-1:0] WB_DBDataSrc;
  logic [DW-1:0] WB_PCadd4, WB_DataFromMemory, WB_DataFromALU;
  logic [RW-1:0] WB_WriteReg;
  logic [1:0]    Occupancy;
  beat_t         inBeat;

  mem_wb_skid_register #(.DATA_W(DW), .REG_W(RW), .SRC_W(SW)) dut (
    .Clk                (Clk),
    .Reset_n            (Reset_n),
    .MEM_Valid          (MEM_Valid),
    .MEM_Ready          (MEM_Ready),
    .MEM_Flush          (MEM_Flush),
    .MEM_DBDataSrc      (inBeat.src),
    .MEM_RegWre         (inBeat.rw),
    .MEM_PCadd4         (inBeat.pc),
    .MEM_DataFromMemory (inBeat.mem),
    .MEM_DataFromALU    (inBeat.alu),
    .MEM_WriteReg       (inBeat.wr),
    .WB_Valid           (WB_Valid),
    .WB_Ready           (WB_Ready),
    .WB_DBDataSrc       (WB_DBDataSrc),
    .WB_RegWre          (WB_RegWre),
    .WB_PCadd4          (WB_PCadd4),
    .WB_DataFromMemory  (WB_DataFromMemory),
    .WB_DataFromALU     (WB_DataFromALU),
    .WB_WriteReg        (WB_WriteReg),
    .Occupancy          (Occupancy)
  );

  // Reference: an ordered list of accepted beats, capacity two.
  beat_t modelQ[$];
  beat_t lastHead;
  int errors = 0;
  int checks = 0;

  function automatic beat_t randBeat();
    beat_t b;
    b.src = SW'($urandom);
    b.rw  = 1'($urandom);
    b.pc  = $urandom;
    b.mem = $urandom;
    b.alu = $urandom;
    b.wr  = RW'($urandom);
    return b;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    beat_t h;
    logic  v;
    v = (modelQ.size() != 0);
    h = v ? modelQ[0] : lastHead;
    check({tag, ".valid"}, WB_Valid, v);
    check({tag, ".occ"}, Occupancy, 64'(modelQ.size()));
    check({tag, ".mready"}, MEM_Ready, modelQ.size() < 2);
    check({tag, ".src"}, WB_DBDataSrc, h.src);
    check({tag, ".regwre"}, WB_RegWre, h.rw & v);
    check({tag, ".pc"}, WB_PCadd4, h.pc);
    check({tag, ".mem"}, WB_DataFromMemory, h.mem);
    check({tag, ".alu"}, WB_DataFromALU, h.alu);
    check({tag, ".wr"}, WB_WriteReg, h.wr);
  endtask

  task automatic checkZero(input string tag);
    check({tag, ".valid"}, WB_Valid, 0);
    check({tag, ".regwre"}, WB_RegWre, 0);
    check({tag, ".occ"}, Occupancy, 0);
    check({tag, ".mready"}, MEM_Ready, 0);
    check({tag, ".data"}, {WB_DBDataSrc, WB_WriteReg, WB_PCadd4}, 0);
    check({tag, ".data2"}, {WB_DataFromMemory, WB_DataFromALU}, 0);
  endtask

  task automatic step(input string tag);
    int    n;
    bit    acc, xfer, fl;
    beat_t b;
    n    = modelQ.size();
    acc  = MEM_Valid && (n < 2) && !MEM_Flush;
    xfer = (n > 0) && WB_Ready;
    fl   = MEM_Flush;
    b    = inBeat;
    @(posedge Clk);
    if (fl) begin
      modelQ.delete();
    end else begin
      if (xfer) void'(modelQ.pop_front());
      if (acc) modelQ.push_back(b);
    end
    if (modelQ.size() != 0) lastHead = modelQ[0];
    #1;
    checkAll(tag);
  endtask

  initial begin
    Reset_n   = 1'b0;
    MEM_Valid = 1'b1;
    MEM_Flush = 1'b0;
    WB_Ready  = 1'b1;
    inBeat    = randBeat();
    lastHead  = '0;
    #2 checkZero("reset0");
    @(posedge Clk);
    #1 checkZero("reset_clk");
    #2 Reset_n = 1'b1;

    // Single beat
    inBeat = '{src: 2'd1, rw: 1'b1, pc: 32'h12341234, mem: 32'h0, alu: 32'h0, wr: 5'b10101};
    MEM_Valid = 1'b1;
    WB_Ready  = 1'b1;
    step("single");
    check("single.occ1", Occupancy, 1);
    check("single.pc_lit", WB_PCadd4, 32'h12341234);
    check("single.wr_lit", WB_WriteReg, 5'b10101);
    MEM_Valid = 1'b0;
    step("single_drain");
    check("single.occ0", Occupancy, 0);
    check("single.valid0", WB_Valid, 0);

    // Back-pressure
    WB_Ready  = 1'b0;
    MEM_Valid = 1'b1;
    inBeat = randBeat(); inBeat.alu = 32'h5A5A5A5A;
    step("bp1");
    inBeat = randBeat(); inBeat.alu = 32'h5A;
    step("bp2");
    check("bp.occ2", Occupancy, 2);
    check("bp.mready0", MEM_Ready, 0);
    check("bp.head", WB_DataFromALU, 32'h5A5A5A5A);
    inBeat = randBeat();
    step("bp_stall");
    check("bp.head_stable", WB_DataFromALU, 32'h5A5A5A5A);
    MEM_Valid = 1'b0;
    WB_Ready  = 1'b1;
    step("bp_rel1");
    check("bp.second", WB_DataFromALU, 32'h5A);
    step("bp_rel2");

    // Full throughput
    MEM_Valid = 1'b1;
    WB_Ready  = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      inBeat = randBeat(); inBeat.mem = i;
      step("tp");
      check("tp.occ_le1", Occupancy <= 2'd1, 1);
      check("tp.order", WB_DataFromMemory, i);
    end
    MEM_Valid = 1'b0;
    step("tp_drain");

    // Flush while FULL with a simultaneous incoming beat
    WB_Ready  = 1'b0;
    MEM_Valid = 1'b1;
    inBeat = randBeat(); step("fl1");
    inBeat = randBeat(); step("fl2");
    inBeat = randBeat(); inBeat.alu = 32'hDEAD0000;
    MEM_Flush = 1'b1;
    step("flush");
    check("flush.valid0", WB_Valid, 0);
    check("flush.occ0", Occupancy, 0);
    MEM_Flush = 1'b0;
    MEM_Valid = 1'b0;
    WB_Ready  = 1'b1;
    step("flush_idle");
    check("flush.still_empty", WB_Valid, 0);
    inBeat = randBeat(); inBeat.alu = 32'h0000BEEF;
    MEM_Valid = 1'b1;
    step("flush_new");
    check("flush.new_head", WB_DataFromALU, 32'h0000BEEF);
    MEM_Valid = 1'b0;
    step("flush_drain");

    // Reset mid-cycle while ONE
    WB_Ready  = 1'b0;
    MEM_Valid = 1'b1;
    inBeat = randBeat();
    step("rst_fill");
    MEM_Valid = 1'b0;
    #3 Reset_n = 1'b0;
    #1 checkZero("rst_mid");
    modelQ.delete();
    lastHead = '0;
    #1 Reset_n = 1'b1;
    inBeat = randBeat(); inBeat.wr = 5'b10;
    MEM_Valid = 1'b1;
    WB_Ready  = 1'b1;
    step("rst_after");
    check("rst.new_wr", WB_WriteReg, 5'b10);
    check("rst.new_valid", WB_Valid, 1);
    MEM_Valid = 1'b0;
    step("rst_drain");

    // Random traffic against the queue model
    for (int i = 0; i < 400; i++) begin
      MEM_Valid = ($urandom_range(0, 3) != 0);
      WB_Ready  = ($urandom_range(0, 2) != 0);
      MEM_Flush = ($urandom_range(0, 19) == 0);
      inBeat    = randBeat();
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
